instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Fetch stage directly upstream of the instruction register. Holds the PC and issues word reads to
//  memory over a req/ack handshake. Buffers the returned word, then presents it on ir_in with a
//  one-cycle ir_ld strobe, which is the IR's `in`/`ld` pair.
//  Handles jump redirects, flushes of in-flight reads, and halt.
// PARAMETERS
//  SIZE        32  instruction/data word width (matches IR SIZE)
//  ADDR_WIDTH  16  PC / memory word-address width
//  RESET_PC    0   PC value loaded on reset
// PORTS
//  clk           in   1           rising-edge clock
//  rst           in   1           synchronous active-high reset
//  mem_rd        out  1           read request; held until mem_ack
//  mem_addr      out  ADDR_WIDTH  read address; stable while mem_rd=1
//  mem_ack       in   1           read data valid this cycle; only meaningful while mem_rd=1
//  mem_data      in   SIZE        read data, sampled when mem_rd & mem_ack
//  ir_in         out  SIZE        instruction word to IR `in`
//  ir_ld         out  1           one-cycle load strobe to IR `ld`
//  decode_ready  in   1           downstream control accepts a new instruction this cycle
//  jump          in   1           redirect request, single-cycle pulse
//  jump_addr     in   ADDR_WIDTH  redirect target
//  halt          in   1           level; stop fetching after current handoff
//  pc            out  ADDR_WIDTH  address of the next word to fetch
//  busy          out  1           state != HALTED
// BEHAVIOUR
//  - Reset: pc=RESET_PC, state=FETCH, buffer=0, mem_rd=0 during the reset cycle, ir_ld=0, ir_in=0.
//  - States:
//      FETCH: mem_rd=1, mem_addr=pc.
//        ack  -> buf<=mem_data, pc<=pc+1, go HOLD.
//        else -> stay FETCH.
//      HOLD: ir_in=buf, ir_ld=decode_ready (combinational).
//        ir_ld & !halt -> FETCH.
//        ir_ld & halt  -> HALTED.
//        else          -> stay HOLD.
//      DRAIN: mem_rd=1, mem_addr=held address. Discards the stale read.
//        ack -> FETCH; buf and pc are unchanged.
//      HALTED: mem_rd=0. !halt -> FETCH.
//  - Throughput: 2 cycles/instruction with a zero-wait memory (ack in the same cycle as mem_rd).
//  - Jump has top priority in every state:
//      * pc<=jump_addr; buf is invalidated; ir_ld is forced to 0 that cycle.
//      * From FETCH without ack: go DRAIN. The request already issued must complete, and its
//        mem_addr stays at the old address; the address is held in a register.
//      * From FETCH with ack in the same cycle: data is dropped, go FETCH.
//      * From HOLD: go FETCH.
//      * From DRAIN: stay in DRAIN; the pc is updated again.
//      * From HALTED: pc is updated; stay HALTED while halt=1.
//  - mem_addr rule: equals pc in FETCH. In DRAIN it equals the latched address of the abandoned read.
//  - PC arithmetic: unsigned modulo 2^ADDR_WIDTH; 2^ADDR_WIDTH-1 wraps to 0, with no flag.
//  - Halt is sampled only in HOLD at handoff and in HALTED. Asserting it mid-FETCH lets that fetch
//    and its handoff complete.
//  - Reset mid-operation: any outstanding read is abandoned without drain. Memory must tolerate a
//    request being withdrawn on reset.
//  - ir_ld never asserts in two consecutive cycles. ir_in is stable whenever ir_ld=1.
// STRUCTURE
//  - cpu_pkg: typedef enum logic [1:0] {FETCH, HOLD, DRAIN, HALTED} fetch_state_e.
//  - PC is one cpu_reg #(ADDR_WIDTH) instance; its ld is driven on ack-advance or jump.
//  - The instruction buffer and drain address are plain flops in this module.
//  - No further sub-modules.
// TESTING
//  1. Reset, RESET_PC=0, zero-wait memory returning data=addr+0x100, decode_ready=1
//     -> ir_ld on alternate cycles with ir_in = 0x100, 0x101, 0x102; pc = 1, 2, 3.
//  2. mem_ack delayed 3 cycles per read
//     -> mem_addr stable and mem_rd high for 4 cycles; exactly one ir_ld per word.
//  3. decode_ready=0 for 5 cycles while in HOLD
//     -> no ir_ld, no new mem_rd, ir_in held; ir_ld fires on the first decode_ready=1.
//  4. jump to 0x40 mid-FETCH with ack arriving 2 cycles later
//     -> DRAIN, stale data never loaded, next mem_addr=0x40, next ir_in=mem[0x40].
//  5. jump in HOLD with decode_ready=1 the same cycle
//     -> ir_ld=0 that cycle; next fetch from jump_addr.
//  6. halt during FETCH at pc=0xFFFF (ADDR_WIDTH=16)
//     -> word handed off, pc wraps to 0x0000, HALTED, mem_rd=0, busy=0.
//     Release halt -> fetch from 0x0000.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU types: the instruction-fetch sequencer states.
package cpu_pkg;

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        DRAIN,
        HALTED
    } fetch_state_e;

endpackage

// File: rtl/cpu_reg.sv
// Loadable register with synchronous active-high reset to a parameterised value.
module cpu_reg #(
    parameter int unsigned    SIZE      = 32,
    parameter logic [SIZE-1:0] RESET_VAL = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ld_i,
    input  logic [SIZE-1:0] in_i,
    output logic [SIZE-1:0] out_o
);

    logic [SIZE-1:0] val_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            val_q <= RESET_VAL;
        end else if (ld_i) begin
            val_q <= in_i;
        end
    end

    assign out_o = val_q;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, reads words over req/ack and hands each one to the IR
// with a single-cycle ir_ld strobe. Supports jump redirect, stale-read drain and halt.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int unsigned           SIZE       = 32,
    parameter int unsigned           ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  mem_rd,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [SIZE-1:0]       mem_data,
    output logic [SIZE-1:0]       ir_in,
    output logic                  ir_ld,
    input  logic                  decode_ready,
    input  logic                  jump,
    input  logic [ADDR_WIDTH-1:0] jump_addr,
    input  logic                  halt,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  busy
);

    localparam logic [ADDR_WIDTH-1:0] PcStep = 1;

    fetch_state_e          state_q;
    logic [SIZE-1:0]       buf_q;
    logic [ADDR_WIDTH-1:0] drain_addr_q;
    logic                  pc_ld;
    logic [ADDR_WIDTH-1:0] pc_d;

    // Natural overflow of the adder gives the required modulo-2^ADDR_WIDTH wrap.
    always_comb begin
        pc_ld = jump || (state_q == FETCH && mem_ack);
        pc_d  = jump ? jump_addr : pc + PcStep;
    end

    cpu_reg #(
        .SIZE      (ADDR_WIDTH),
        .RESET_VAL (RESET_PC)
    ) u_pc (
        .clk   (clk),
        .rst   (rst),
        .ld_i  (pc_ld),
        .in_i  (pc_d),
        .out_o (pc)
    );

    always_comb begin
        mem_rd   = (state_q == FETCH || state_q == DRAIN) && !rst;
        mem_addr = (state_q == DRAIN) ? drain_addr_q : pc;
        ir_in    = buf_q;
        ir_ld    = (state_q == HOLD) && decode_ready && !jump && !rst;
        busy     = (state_q != HALTED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FETCH;
            buf_q        <= '0;
            drain_addr_q <= '0;
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (jump) begin
                        // An un-acked request is still live at memory; wait it out at its address.
                        if (!mem_ack) begin
                            drain_addr_q <= pc;
                            state_q      <= DRAIN;
                        end
                    end else if (mem_ack) begin
                        buf_q   <= mem_data;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (jump) begin
                        state_q <= FETCH;
                    end else if (ir_ld) begin
                        state_q <= halt ? HALTED : FETCH;
                    end
                end
                DRAIN: begin
                    if (!jump && mem_ack) begin
                        state_q <= FETCH;
                    end
                end
                HALTED: begin
                    if (!halt) begin
                        state_q <= FETCH;
                    end
                end
                default: state_q <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: stimulus pushes expected handoffs, a monitor pops on ir_ld.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_data;
    logic [31:0] ir_in;
    logic        ir_ld;
    logic        decode_ready;
    logic        jump;
    logic [15:0] jump_addr;
    logic        halt;
    logic [15:0] pc;
    logic        busy;

    typedef struct packed {
        logic [31:0] data;
        logic [15:0] pc;
    } exp_t;

    exp_t exp_q[$];
    int   ld_cyc[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   ack_delay = 0;
    int   mem_cnt = 0;
    logic prev_ld = 1'b0;

    always #5 clk = ~clk;

    instr_fetch #(
        .SIZE       (32),
        .ADDR_WIDTH (16),
        .RESET_PC   (16'h0000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_rd       (mem_rd),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_data     (mem_data),
        .ir_in        (ir_in),
        .ir_ld        (ir_ld),
        .decode_ready (decode_ready),
        .jump         (jump),
        .jump_addr    (jump_addr),
        .halt         (halt),
        .pc           (pc),
        .busy         (busy)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Memory: acks after ack_delay wait cycles, data = addr + 0x100.
    always @(negedge clk) begin
        #1;
        if (mem_rd) begin
            if (mem_cnt >= ack_delay) begin
                mem_ack  = 1'b1;
                mem_data = {16'h0000, mem_addr} + 32'h0000_0100;
                mem_cnt  = 0;
            end else begin
                mem_ack = 1'b0;
                mem_cnt++;
            end
        end else begin
            mem_ack = 1'b0;
            mem_cnt = 0;
        end
    end

    // Monitor: every ir_ld must match the oldest expected handoff and never follow another ir_ld.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!rst) begin
            if (ir_ld) begin
                ld_cyc.push_back(cyc);
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_ld got ir_in=%h pc=%h want no load", ir_in, pc);
                end else begin
                    e = exp_q.pop_front();
                    if (prev_ld || ir_in !== e.data || pc !== e.pc) begin
                        bad++;
                        $display("FAIL handoff got ir_in=%h pc=%h back2back=%0b want ir_in=%h pc=%h",
                                 ir_in, pc, prev_ld, e.data, e.pc);
                    end
                end
            end
            prev_ld = ir_ld;
        end else begin
            prev_ld = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, req);
        end
    endtask

    task automatic push(input logic [31:0] data, input logic [15:0] p);
        exp_t e;
        e.data = data;
        e.pc   = p;
        exp_q.push_back(e);
    endtask

    task automatic wait_empty(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Returns at +3 within the first cycle the DUT sits in HOLD (no request, still busy).
    task automatic wait_hold(input string name);
        int n = 0;
        #3;
        while (mem_rd && n < 50) begin
            @(negedge clk);
            #3;
            n++;
        end
        chk(name, mem_rd, 1'b0);
    endtask

    initial begin
        rst = 1'b1; decode_ready = 1'b0; jump = 1'b0; jump_addr = '0; halt = 1'b0;
        mem_ack = 1'b0; mem_data = '0;
        repeat (2) @(negedge clk);
        #3;
        chk("rst_mem_rd", mem_rd, 1'b0);
        chk("rst_ir_ld", ir_ld, 1'b0);
        chk("rst_ir_in", ir_in, 32'h0);
        chk("rst_pc", pc, 16'h0);
        chk("rst_busy", busy, 1'b1);

        // Zero-wait streaming: one handoff every other cycle.
        @(negedge clk);
        rst = 1'b0; decode_ready = 1'b1; ack_delay = 0;
        push(32'h100, 16'h1); push(32'h101, 16'h2); push(32'h102, 16'h3);
        #3;
        chk("t1_mem_rd", mem_rd, 1'b1);
        chk("t1_mem_addr", mem_addr, 16'h0);
        wait_empty("t1_drain_q");
        chk("t1_ld_count", ld_cyc.size(), 3);
        if (ld_cyc.size() >= 3) begin
            chk("t1_gap01", ld_cyc[1] - ld_cyc[0], 2);
            chk("t1_gap12", ld_cyc[2] - ld_cyc[1], 2);
        end
        decode_ready = 1'b0;

        // Stalled downstream: word 0x103 waits in HOLD.
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            #3;
            chk("t3_no_rd", mem_rd, 1'b0);
            chk("t3_no_ld", ir_ld, 1'b0);
            chk("t3_ir_in", ir_in, 32'h103);
            @(negedge clk);
        end
        ack_delay = 3;
        push(32'h103, 16'h4); push(32'h104, 16'h5); push(32'h105, 16'h6);
        decode_ready = 1'b1;
        #3;
        chk("t3_release_ld", ir_ld, 1'b1);

        // Three wait states: request held four cycles at a stable address.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #3;
            chk("t2_mem_rd", mem_rd, 1'b1);
            chk("t2_mem_addr", mem_addr, 16'h4);
            chk("t2_ack", mem_ack, (i == 3));
        end
        wait_empty("t2_drain_q");

        // Jump in the first cycle of FETCH 0x6, its ack lands two cycles later.
        ack_delay = 2; jump = 1'b1; jump_addr = 16'h40;
        push(32'h140, 16'h41);
        #3;
        chk("t4_jump_ld", ir_ld, 1'b0);
        chk("t4_jump_addr", mem_addr, 16'h6);
        @(negedge clk);
        jump = 1'b0;
        #3;
        chk("t4_drain_addr", mem_addr, 16'h6);
        chk("t4_drain_rd", mem_rd, 1'b1);
        chk("t4_drain_pc", pc, 16'h40);
        @(negedge clk);
        #3;
        chk("t4_stale_addr", mem_addr, 16'h6);
        chk("t4_stale_ack", mem_ack, 1'b1);
        @(negedge clk);
        #3;
        chk("t4_new_addr", mem_addr, 16'h40);
        chk("t4_new_rd", mem_rd, 1'b1);
        wait_empty("t4_drain_q");

        // Jump while HOLD offers 0x141 with decode_ready high.
        decode_ready = 1'b0;
        wait_hold("t5_reach_hold");
        @(negedge clk);
        decode_ready = 1'b1; jump = 1'b1; jump_addr = 16'h80;
        push(32'h180, 16'h81);
        #3;
        chk("t5_jump_ld", ir_ld, 1'b0);
        @(negedge clk);
        jump = 1'b0;
        #3;
        chk("t5_fetch_addr", mem_addr, 16'h80);
        chk("t5_fetch_rd", mem_rd, 1'b1);
        wait_empty("t5_drain_q");

        // Halt raised during FETCH at 0xFFFF: handoff completes, pc wraps, then halted.
        decode_ready = 1'b0;
        wait_hold("t6_reach_hold");
        @(negedge clk);
        ack_delay = 0; decode_ready = 1'b1; jump = 1'b1; jump_addr = 16'hFFFF;
        @(negedge clk);
        jump = 1'b0; halt = 1'b1;
        push(32'h0001_00FF, 16'h0000);
        #3;
        chk("t6_top_addr", mem_addr, 16'hFFFF);
        wait_empty("t6_drain_q");
        #3;
        chk("t6_halt_rd", mem_rd, 1'b0);
        chk("t6_halt_busy", busy, 1'b0);
        chk("t6_halt_pc", pc, 16'h0);
        @(negedge clk);
        #3;
        chk("t6_halt_hold", busy, 1'b0);
        @(negedge clk);
        halt = 1'b0;
        push(32'h100, 16'h1);
        @(negedge clk);
        #3;
        chk("t6_resume_busy", busy, 1'b1);
        chk("t6_resume_addr", mem_addr, 16'h0);
        chk("t6_resume_rd", mem_rd, 1'b1);
        wait_empty("t6_resume_q");

        // Reset mid-FETCH withdraws the request immediately.
        rst = 1'b1;
        #3;
        chk("t7_rst_rd", mem_rd, 1'b0);
        chk("t7_rst_ld", ir_ld, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        push(32'h100, 16'h1);
        #3;
        chk("t7_rst_pc", pc, 16'h0);
        wait_empty("t7_drain_q");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
